if_stage: RTL and testbench

- Instruction-fetch stage of the veriRISCV 5-stage core, directly upstream of the ID stage.
- Owns the fetch PC and issues word fetches on a single-outstanding instruction bus.
- Drives the IF/ID pipeline registers (if2id_valid/pc/instruction) with one skid entry so stalls never lose a returned word.
- Redirects on branch/jump/trap from EX and discards stale responses.

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/if_skid_buffer.sv | 46 ++++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage: fetch FSM state
//   encoding, core-wide constants (NOP, reset vector, data width) and a
//   word-alignment helper used on redirect targets.
`timescale 1ns/1ps
package if_stage_pkg;

    localparam int XLEN = 32;

    // Fetch FSM: how many requests are outstanding, and whether the
    // response for the outstanding one is still wanted.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // nothing outstanding
        S_WAIT  = 2'd1,   // one outstanding, response kept
        S_DROP  = 2'd2    // one outstanding, response discarded
    } if_state_e;

    localparam logic [XLEN-1:0] CORE_NOP_INSTR    = 32'h0000_0013; // addi x0,x0,0
    localparam logic [XLEN-1:0] CORE_RESET_VECTOR = 32'h0000_0000;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer
//   One-entry holding register for a fetched word that arrives while ID is
//   stalled. Loaded with (pc, instruction), emptied by unload or clear.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     load                capture load_pc/load_instr, mark valid
//     unload              entry consumed by the IF/ID registers
//     clear               flush (redirect)
//     load_pc/load_instr  entry contents to capture
//     buf_valid           entry holds a word
//     buf_pc/buf_instr    stored entry
`timescale 1ns/1ps
module if_skid_buffer
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            buf_valid,
    output logic [XLEN-1:0] buf_pc,
    output logic [XLEN-1:0] buf_instr
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_valid <= 1'b1;
        end else if (unload) begin
            buf_valid <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while buf_valid is set.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_pc    <= load_pc;
            buf_instr <= load_instr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage. Owns the fetch PC, issues word fetches on a
//   single-outstanding instruction bus, and drives the IF/ID registers with a
//   one-entry skid buffer so a word returning during an ID stall is kept.
//   Redirects from EX flush IF/ID and discard stale bus responses.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     if_stall                   ID cannot accept; hold IF/ID
//     branch_take, branch_pc     redirect request and target
//     ibus_req/addr/ready        request channel (handshake = req & ready)
//     ibus_rvalid/rdata          response for the oldest accepted request
//     if2id_valid/pc/instruction IF/ID pipeline registers
`timescale 1ns/1ps
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = CORE_RESET_VECTOR,
    parameter logic [XLEN-1:0] NOP_INSTR    = CORE_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_stall,
    input  logic            branch_take,
    input  logic [XLEN-1:0] branch_pc,
    output logic            ibus_req,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_ready,
    input  logic            ibus_rvalid,
    input  logic [XLEN-1:0] ibus_rdata,
    output logic            if2id_valid,
    output logic [XLEN-1:0] if2id_pc,
    output logic [XLEN-1:0] if2id_instruction
);

    if_state_e       state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] req_pc_reg;     // PC of the outstanding request
    logic            outstanding;
    logic            handshake;
    logic            accept;
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc, buf_instr;
    logic            buf_load, buf_unload;

    assign outstanding = (state_reg == S_WAIT) || (state_reg == S_DROP);
    assign accept      = ibus_rvalid && (state_reg == S_WAIT) && !branch_take;
    assign handshake   = ibus_req && ibus_ready;
    assign ibus_addr   = pc_reg;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // A redirect with a request still in flight must remember to swallow
    // that response; if the response lands in the redirect cycle it is
    // already gone and we can fetch the target straight away.
    always_comb begin
        state_next = state_reg;
        if (branch_take) begin
            state_next = (outstanding && !ibus_rvalid) ? S_DROP : S_FETCH;
        end else if (handshake) begin
            state_next = S_WAIT;
        end else if (outstanding && ibus_rvalid) begin
            state_next = S_FETCH;
        end
    end

    // ---------------- FSM: outputs ----------------
    // Issuing in S_WAIT alongside the response gives one fetch per cycle,
    // but only when that response goes straight into IF/ID (no stall);
    // otherwise the skid entry would be needed for two words.
    always_comb begin
        ibus_req = 1'b0;
        if (!rst && !buf_valid && !branch_take) begin
            ibus_req = (state_reg == S_FETCH) ||
                       ((state_reg == S_WAIT) && ibus_rvalid && !if_stall);
        end
    end

    // ---------------- fetch PC ----------------
    always_comb begin
        pc_next = pc_reg;
        if (branch_take) begin
            pc_next = align_word(branch_pc);
        end else if (handshake) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= RESET_VECTOR;
            req_pc_reg <= RESET_VECTOR;
        end else begin
            pc_reg <= pc_next;
            if (handshake) begin
                req_pc_reg <= pc_reg;
            end
        end
    end

    // ---------------- skid buffer ----------------
    // While the buffer is full nothing can be outstanding (issue is
    // blocked), so load and unload never coincide.
    assign buf_load   = accept && if_stall;
    assign buf_unload = !branch_take && !if_stall && buf_valid;

    if_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .unload     (buf_unload),
        .clear      (branch_take),
        .load_pc    (req_pc_reg),
        .load_instr (ibus_rdata),
        .buf_valid  (buf_valid),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr)
    );

    // ---------------- IF/ID registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            if2id_valid       <= 1'b0;
            if2id_pc          <= '0;
            if2id_instruction <= NOP_INSTR;
        end else if (branch_take) begin
            if2id_valid <= 1'b0;
        end else if (!if_stall) begin
            if (buf_valid) begin
                if2id_valid       <= 1'b1;
                if2id_pc          <= buf_pc;
                if2id_instruction <= buf_instr;
            end else if (accept) begin
                if2id_valid       <= 1'b1;
                if2id_pc          <= req_pc_reg;
                if2id_instruction <= ibus_rdata;
            end else begin
                if2id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage
//   Self-checking bench for if_stage. A bus model answers fetches with
//   rdata = addr ^ A5A5A5A5 after a configurable latency. Every response the
//   bench delivers that no reset/redirect has made stale is pushed into a
//   scoreboard queue; a separate monitor pops one entry each cycle ID
//   consumes a word (valid & ~stall) and also checks program order
//   (sequential PCs from the latest reset vector or redirect target).
`timescale 1ns/1ps
module tb_if_stage;
    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall = 1'b0;
    logic        branch_take = 1'b0;
    logic [31:0] branch_pc = '0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ready = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic        if2id_valid;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_instruction;

    if_stage dut (
        .clk               (clk),
        .rst               (rst),
        .if_stall          (if_stall),
        .branch_take       (branch_take),
        .branch_pc         (branch_pc),
        .ibus_req          (ibus_req),
        .ibus_addr         (ibus_addr),
        .ibus_ready        (ibus_ready),
        .ibus_rvalid       (ibus_rvalid),
        .ibus_rdata        (ibus_rdata),
        .if2id_valid       (if2id_valid),
        .if2id_pc          (if2id_pc),
        .if2id_instruction (if2id_instruction)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] hs_log[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_hs_cyc = -1;
    int first_cons_cyc = -1;

    // bus model and stimulus knobs
    int          ready_pct = 100, lat_min = 1, lat_max = 1;
    logic        pend = 1'b0, pend_rst = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0, pend_epoch = 0, epoch = 0;
    logic        prev_wait = 1'b0, last_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc = RV;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_log(input int idx, input logic [31:0] req, input string name);
        if (hs_log.size() > idx) begin
            chk(name, hs_log[idx], req);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s no fetch issued, required=%h", name, req);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then let the bus
    // model observe the request that will be sampled at the next rising edge.
    task automatic step(input logic r, input logic st, input logic bt, input logic [31:0] bpc);
        @(negedge clk);
        #1;
        cyc++;
        rst = r; if_stall = st; branch_take = bt; branch_pc = bpc;
        ibus_ready = ($urandom_range(0, 99) < ready_pct);
        if (pend && (pend_cnt == 0 || (pend_rst && !r))) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = pend_addr ^ SALT;
        end else begin
            ibus_rvalid = 1'b0;
            ibus_rdata  = $urandom;
        end
        #1;
        if (r) chk("req_in_reset", {31'd0, ibus_req}, 32'd0);
        if (prev_wait && !r && !bt) begin
            chk("req_held", {31'd0, ibus_req}, 32'd1);
            chk("addr_stable", ibus_addr, prev_addr);
        end
        prev_wait = ibus_req && !ibus_ready && !r;
        prev_addr = ibus_addr;
        last_req  = ibus_req;
        if (ibus_rvalid) begin
            if (!r && !bt && pend_epoch == epoch)
                exp_q.push_back('{pc: pend_addr, instr: pend_addr ^ SALT});
            pend = 1'b0;
            pend_rst = 1'b0;
        end else if (pend && pend_cnt > 0) begin
            pend_cnt--;
        end
        if (r) begin
            epoch++;
            if (pend) pend_rst = 1'b1;
        end else if (bt) begin
            epoch++;
        end
        if (ibus_req && ibus_ready) begin
            chk("one_outstanding", {31'd0, pend}, 32'd0);
            chk("addr_aligned", {30'd0, ibus_addr[1:0]}, 32'd0);
            pend       = 1'b1;
            pend_rst   = 1'b0;
            pend_addr  = ibus_addr;
            pend_cnt   = $urandom_range(lat_min, lat_max) - 1;
            pend_epoch = epoch;
            hs_log.push_back(ibus_addr);
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
    endtask

    // Monitor: runs after the driver has settled this cycle's inputs.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            exp_q.delete();
            exp_pc = RV;
        end else begin
            if (if2id_valid && !if_stall) begin
                if (first_cons_cyc < 0) first_cons_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual pc=%h instr=%h required=none", if2id_pc, if2id_instruction);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("id_pc", if2id_pc, e.pc);
                    chk("id_instr", if2id_instruction, e.instr);
                    chk("program_order", if2id_pc, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (branch_take) begin
                exp_q.delete();
                exp_pc = {branch_pc[31:2], 2'b00};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset and streaming at one word per cycle
        repeat (3) step(1, 0, 0, 0);
        first_hs_cyc = -1; first_cons_cyc = -1; hs_log.delete();
        step(0, 0, 0, 0);
        chk("rst_valid", {31'd0, if2id_valid}, 32'd0);
        chk("rst_pc", if2id_pc, 32'd0);
        chk("rst_instr", if2id_instruction, NOP);
        repeat (7) step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) chk_log(i, 32'(4 * i), "stream_addr");
        chk("fetch_latency", 32'(first_cons_cyc - first_hs_cyc), 32'd2);

        // stall three cycles while a word returns: buffered, no new request
        step(0, 1, 0, 0); chk("stall_noreq1", {31'd0, last_req}, 32'd0);
        step(0, 1, 0, 0); chk("stall_noreq2", {31'd0, last_req}, 32'd0);
        step(0, 1, 0, 0); chk("stall_noreq3", {31'd0, last_req}, 32'd0);
        step(0, 0, 0, 0); chk("release_noreq", {31'd0, last_req}, 32'd0);
        step(0, 0, 0, 0); chk("resume_req", {31'd0, last_req}, 32'd1);
        repeat (3) step(0, 0, 0, 0);

        // redirect while a 2-cycle request is outstanding
        lat_min = 2; lat_max = 2;
        n = 0;
        do begin step(0, 0, 0, 0); n++; end while (!(pend && pend_cnt != 0) && n < 20);
        hs_log.delete();
        step(0, 0, 1, 32'h100);
        step(0, 0, 0, 0); chk("redir_bubble", {31'd0, if2id_valid}, 32'd0);
        repeat (5) step(0, 0, 0, 0);
        chk_log(0, 32'h100, "redir_target");

        // redirect while stalled with the skid buffer full
        lat_min = 1; lat_max = 1;
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        hs_log.delete();
        step(0, 1, 1, 32'h200);
        step(0, 0, 0, 0); chk("flush_valid", {31'd0, if2id_valid}, 32'd0);
        repeat (3) step(0, 0, 0, 0);
        chk_log(0, 32'h200, "flush_target");

        // redirect in the same cycle as a response
        hs_log.delete();
        step(0, 0, 1, 32'h300);
        repeat (3) step(0, 0, 0, 0);
        chk_log(0, 32'h300, "redir_rvalid_target");

        // bus not ready for four cycles
        ready_pct = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("ready_low_bubble3", {31'd0, if2id_valid}, 32'd0);
        step(0, 0, 0, 0); chk("ready_low_bubble4", {31'd0, if2id_valid}, 32'd0);
        ready_pct = 100;
        repeat (3) step(0, 0, 0, 0);

        // redirect near the top of memory: PC wraps to zero
        hs_log.delete();
        step(0, 0, 1, 32'hFFFF_FFFE);
        repeat (5) step(0, 0, 0, 0);
        chk_log(0, 32'hFFFF_FFFC, "wrap_first");
        chk_log(1, 32'h0000_0000, "wrap_second");

        // reset while waiting on a slow response
        lat_min = 3; lat_max = 3;
        n = 0;
        do begin step(0, 0, 0, 0); n++; end while (!(pend && pend_cnt != 0) && n < 20);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        hs_log.delete();
        repeat (6) step(0, 0, 0, 0);
        chk_log(0, RV, "post_reset_addr");

        // randomized traffic
        ready_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            logic r, st, bt;
            r  = ($urandom_range(0, 999) < 5);
            st = ($urandom_range(0, 99) < 20);
            bt = !r && ($urandom_range(0, 99) < 3);
            step(r, st, bt, $urandom);
        end

        // drain: every delivered word must have reached ID
        ready_pct = 0;
        repeat (10) step(0, 0, 0, 0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
